// File: rtl/bus_dma_pkg.sv
// Shared types for the bus DMA master: state encoding, latched command, word address.
// Latency: n/a (types only).
// Backpressure: n/a.
package bus_dma_pkg;

    localparam int ADDR_W = 22;

    // Word address on the CPU-side bus, bit 0 (byte lane) is implied by uds/lds.
    typedef logic [ADDR_W:1] waddr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_GAP,
        ST_WR,
        ST_WR_GAP,
        ST_DONE
    } dma_state_e;

    typedef struct packed {
        waddr_t      src;
        waddr_t      dst;
        logic [15:0] len;
        logic        fill;
        logic [15:0] fill_data;
    } dma_cmd_t;

endpackage

// File: rtl/bus_dma_if.sv
// CPU-side bus between an initiator (this engine) and a responder.
// Latency: n/a (wires only).
// Backpressure: responder holds bus_ack low to stretch an access.
interface bus_dma_if;
    import bus_dma_pkg::*;

    logic        bus_cs;
    waddr_t      bus_address;
    logic        bus_uds;
    logic        bus_lds;
    logic        bus_write_strobe;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;
    logic        bus_ack;

    modport master (
        output bus_cs, bus_address, bus_uds, bus_lds, bus_write_strobe, bus_dout,
        input  bus_din, bus_ack
    );

    modport slave (
        input  bus_cs, bus_address, bus_uds, bus_lds, bus_write_strobe, bus_dout,
        output bus_din, bus_ack
    );

endinterface

// File: rtl/bus_dma_master.sv
// Word copy/fill engine acting as a second initiator on the CPU-side bus.
// Latency: copy 5 cycles/word, fill 2 cycles/word, len=0 done 1 cycle after accept (bus_ack high).
// Backpressure: cmd_ready only in IDLE; bus_ack low stretches accesses up to TIMEOUT_CYCLES.
module bus_dma_master
    import bus_dma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  waddr_t      cmd_src,
    input  waddr_t      cmd_dst,
    input  logic [15:0] cmd_len,
    input  logic        cmd_fill,
    input  logic [15:0] cmd_fill_data,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_done,
    bus_dma_if.master   bus
);

    // Last cycle index (counting from 0) an access may still be waiting.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    dma_state_e  state_q, state_d;
    dma_cmd_t    cmd_q;
    logic [15:0] data_q;
    logic [15:0] dout_q;
    logic [15:0] wait_cnt_q;
    logic        to_q;

    logic        accept;
    logic        in_access;
    logic        complete;
    logic        timeout_hit;
    logic [15:0] wr_dat;

    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign in_access = (state_q == ST_RD) || (state_q == ST_WR);
    // The first read cycle only lets the responder register its data, so a
    // read cannot complete until wait_cnt_q has moved off zero.
    assign complete  = bus.bus_ack &&
                       ((state_q == ST_WR) || ((state_q == ST_RD) && (wait_cnt_q != '0)));
    assign timeout_hit = in_access && !complete && (wait_cnt_q == TO_LAST);
    assign wr_dat    = cmd_q.fill ? cmd_q.fill_data : data_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort first, then access completion, then timeout.
    always_comb begin
        state_d = state_q;
        if ((state_q != ST_IDLE) && abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmd_len == '0)  state_d = ST_DONE;
                        else if (cmd_fill)  state_d = ST_WR;
                        else                state_d = ST_RD;
                    end
                end
                ST_RD: begin
                    if (complete)         state_d = ST_RD_GAP;
                    else if (timeout_hit) state_d = ST_DONE;
                end
                ST_RD_GAP: state_d = ST_WR;
                ST_WR: begin
                    if (complete) begin
                        state_d = ((words_done + 16'd1) == cmd_q.len) ? ST_DONE : ST_WR_GAP;
                    end else if (timeout_hit) begin
                        state_d = ST_DONE;
                    end
                end
                ST_WR_GAP: state_d = cmd_q.fill ? ST_WR : ST_RD;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; DONE reports error instead of done after a timeout.
    always_comb begin
        cmd_ready            = (state_q == ST_IDLE);
        busy                 = (state_q != ST_IDLE);
        done                 = (state_q == ST_DONE) && !to_q;
        error                = (state_q == ST_DONE) && to_q;
        bus.bus_cs           = in_access;
        bus.bus_uds          = in_access;
        bus.bus_lds          = in_access;
        bus.bus_write_strobe = (state_q == ST_WR);
        bus.bus_address      = '0;
        if (state_q == ST_RD)      bus.bus_address = cmd_q.src;
        else if (state_q == ST_WR) bus.bus_address = cmd_q.dst;
        bus.bus_dout         = (state_q == ST_WR) ? wr_dat : dout_q;
    end

    // Command latch, address/word counters, read data and per-access wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q      <= '0;
            data_q     <= '0;
            dout_q     <= '0;
            wait_cnt_q <= '0;
            to_q       <= 1'b0;
            words_done <= '0;
        end else begin
            wait_cnt_q <= (in_access && !complete) ? wait_cnt_q + 16'd1 : '0;
            to_q       <= timeout_hit && !abort;
            if (accept) begin
                cmd_q      <= '{src: cmd_src, dst: cmd_dst, len: cmd_len,
                                fill: cmd_fill, fill_data: cmd_fill_data};
                words_done <= '0;
            end
            if ((state_q == ST_RD) && complete && !abort) begin
                data_q    <= bus.bus_din;
                cmd_q.src <= cmd_q.src + waddr_t'(1);
            end
            // Keeps the last driven write word on the bus between writes.
            if (state_q == ST_WR) begin
                dout_q <= wr_dat;
            end
            if ((state_q == ST_WR) && complete && !abort) begin
                cmd_q.dst  <= cmd_q.dst + waddr_t'(1);
                words_done <= words_done + 16'd1;
            end
        end
    end

endmodule

// File: doc/bus_dma_master.md
# bus_dma_master

Word-copy/fill engine that acts as a bus initiator on the CPU-side bus protocol of the MCD212 (`cpu_address`/`cpu_din`/`cpu_dout`, `uds`/`lds`, `write_strobe`, `cs`, `bus_ack`). It drives the strobes and address, waits on the responder's `bus_ack`, and moves word blocks between any two addresses in the 8 MB bus space, or fills a block with a constant. It sits beside the CPU as a second bus master ahead of the bus mux, which is outside this block.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles one access may wait for completion before the engine aborts with `error`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high in IDLE only; command accepted on `cmd_valid && cmd_ready`.
- `cmd_src`  in  22 [22:1]  source word address; ignored in fill mode.
- `cmd_dst`  in  22 [22:1]  destination word address.
- `cmd_len`  in  16  number of words; 0 is legal.
- `cmd_fill`  in  1  1 = write `cmd_fill_data` to every destination word, no reads.
- `cmd_fill_data`  in  16  fill constant.
- `abort`  in  1  cancel the running command.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `error`  out  1  one-cycle pulse on timeout.
- `words_done`  out  16  words written by the current or last command.
- `bus_cs`  out  1  chip select, high whenever strobes are high.
- `bus_address`  out  22 [22:1]  word address.
- `bus_uds`, `bus_lds`  out  1 each  byte strobes; always driven together.
- `bus_write_strobe`  out  1  1 = write, 0 = read.
- `bus_dout`  out  16  write data to the responder's `cpu_din`.
- `bus_din`  in  16  read data from the responder's `cpu_dout`.
- `bus_ack`  in  1  responder ready; high completes the access (see Timing).

## Operation
- Reset values: `cmd_ready`=1, `busy`=`done`=`error`=0, `words_done`=0, all `bus_*` outputs 0, state IDLE.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
- IDLE, on acceptance:
  - Latch src, dst, len, fill, and fill_data. Clear `words_done`.
  - If len=0, go to DONE.
  - Otherwise go to WR if fill, else RD.
- RD: `cs`=`uds`=`lds`=1, write=0, address=src.
  - On completion, latch `bus_din` into the data register, increment src, and go to RD_GAP.
- RD_GAP: all strobes 0 for one cycle, then go to WR.
- WR: `cs`=`uds`=`lds`=`write_strobe`=1, address=dst, `bus_dout` = data register (fill: fill_data).
  - On completion, increment dst and `words_done`.
  - If `words_done`+1 = len, go to DONE; else go to WR_GAP.
- WR_GAP: strobes 0 for one cycle, then go to RD (or WR if fill).
- DONE: `done`=1 for one cycle, then go to IDLE.
- Address arithmetic is 22-bit modulo. 3FFFFF+1 wraps to 000000 silently.
- Timeout:
  - A per-access counter clears on entering RD or WR.
  - If it reaches `TIMEOUT_CYCLES` without completion, the engine drops the strobes the next cycle, pulses `error` for one cycle, and returns to IDLE. No `done` is issued.
- Abort:
  - In any non-IDLE state, the engine goes to IDLE next cycle with strobes low, issuing no `done` and no `error`.
  - `words_done` holds its value.
  - Abort outranks completion and timeout in the same cycle.
- `cmd_valid` outside IDLE is ignored.
- `bus_dout` holds its last value outside WR.

## Timing
- Write completion: a WR cycle with `bus_ack`=1 completes on that edge. Minimum 1 cycle.
- Read completion:
  - The first RD cycle never completes, regardless of `bus_ack`; the responder registers data on that edge.
  - The access completes on the first later RD edge with `bus_ack`=1, sampling `bus_din` there. Minimum 2 cycles.
- There is always at least one strobe-low cycle between consecutive accesses. The responder's read-ack logic depends on it.
- Latency, command accepted on edge 0, `bus_ack` tied high:
  - Copy of n words: RD in cycles 1–2, gap in 3, WR in 4, gap in 5, repeating; `done` is high in cycle 5n.
  - Fill of n words: `done` is high in cycle 2n.
  - len=0: `done` is high in cycle 1, with no bus activity.
- `cmd_ready` returns high in the cycle after `done` or `error` (or after abort).

## Structure
- Package `bus_dma_pkg`:
  - State enum typedef.
  - Packed `dma_cmd_t` struct with fields src, dst, len, fill, fill_data.
  - Address width constant 22.
- Single module. The timeout counter is inline; no sub-module is warranted.

## Test plan
- Copy len=3, src=000100, dst=000200, `bus_ack`=1, memory model: three reads then three writes of matching data; strobes low between accesses; `done` in cycle 15; `words_done`=3.
- RAM-like responder that holds `bus_ack` low in the first read cycle: each read lasts 2 cycles; data sampled from the second cycle; the copy is byte-exact.
- Fill len=4, dst=3FFFFE, data=5AA5: writes to 3FFFFE, 3FFFFF, 000000, 000001 (wrap); `done` in cycle 8.
- len=0: `done` in cycle 1; `bus_cs` never rises; `cmd_ready` high in cycle 2.
- `bus_ack` stuck low, `TIMEOUT_CYCLES`=8: `error` pulses once; strobes drop; `done` never asserts; the next command is accepted normally.
- Abort asserted in the second WR of a len=5 copy: strobes low next cycle; `busy`=0; `words_done`=1; no `done` and no `error`.
